// File: rtl/vme_iack_controller.sv
// VME system-board interrupt handler: prioritises IRQ1..IRQ7 for the CPU and runs
// the bus interrupt-acknowledge cycle that fetches the status/ID vector.
module vme_iack_controller #(
    parameter int unsigned TIMEOUT_CYCLES  = 64,
    parameter logic [7:0]  SPURIOUS_VECTOR = 8'h18
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic [6:0] irq_n,
    output logic [2:0] ipl,
    input  logic       cpu_iack_req,
    output logic       cpu_iack_done,
    output logic [7:0] cpu_vector,
    output logic       cpu_berr,
    output logic       bus_req,
    input  logic       bus_grant,
    output logic       vme_iack_n,
    output logic       vme_as_n,
    output logic       vme_ds0_n,
    output logic [2:0] vme_addr_level,
    input  logic [7:0] vme_data,
    input  logic       vme_dtack_n,
    input  logic       vme_berr_n
);

    localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_REQ_BUS = 3'd1,
        S_ADDR    = 3'd2,
        S_STROBE  = 3'd3,
        S_WAIT    = 3'd4,
        S_RELEASE = 3'd5
    } state_t;

    state_t        state;
    logic [TW-1:0] timer;
    logic [2:0]    level;
    logic [6:0]    irq_meta;
    logic [6:0]    irq_sync;
    logic          dtack_meta;
    logic          dtack_sync;
    logic          berr_meta;
    logic          berr_sync;
    logic [2:0]    ipl_next_c;
    logic          timer_last_c;

    // Highest-numbered asserted IRQ wins; ascending scan lets the top level overwrite.
    always_comb begin
        ipl_next_c = 3'd0;
        for (int i = 0; i < 7; i++) begin
            if (!irq_sync[i]) ipl_next_c = 3'(i + 1);
        end
    end

    assign timer_last_c = (timer == TIMER_LAST);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state          <= S_IDLE;
            timer          <= '0;
            level          <= 3'd0;
            irq_meta       <= '1;
            irq_sync       <= '1;
            dtack_meta     <= 1'b1;
            dtack_sync     <= 1'b1;
            berr_meta      <= 1'b1;
            berr_sync      <= 1'b1;
            ipl            <= 3'd0;
            bus_req        <= 1'b0;
            vme_iack_n     <= 1'b1;
            vme_as_n       <= 1'b1;
            vme_ds0_n      <= 1'b1;
            vme_addr_level <= 3'd0;
            cpu_iack_done  <= 1'b0;
            cpu_vector     <= 8'h00;
            cpu_berr       <= 1'b0;
        end else begin
            irq_meta      <= irq_n;
            irq_sync      <= irq_meta;
            dtack_meta    <= vme_dtack_n;
            dtack_sync    <= dtack_meta;
            berr_meta     <= vme_berr_n;
            berr_sync     <= berr_meta;
            ipl           <= ipl_next_c;
            cpu_iack_done <= 1'b0;

            case (state)
                S_IDLE: begin
                    vme_iack_n     <= 1'b1;
                    vme_as_n       <= 1'b1;
                    vme_ds0_n      <= 1'b1;
                    vme_addr_level <= 3'd0;
                    if (cpu_iack_req) begin
                        if (ipl != 3'd0) begin
                            level   <= ipl;
                            bus_req <= 1'b1;
                            state   <= S_REQ_BUS;
                        end else begin
                            cpu_iack_done <= 1'b1;
                            cpu_vector    <= SPURIOUS_VECTOR;
                            cpu_berr      <= 1'b1;
                        end
                    end
                end
                S_REQ_BUS: begin
                    bus_req <= 1'b1;
                    if (bus_grant) begin
                        vme_addr_level <= level;
                        vme_iack_n     <= 1'b0;
                        state          <= S_ADDR;
                    end
                end
                S_ADDR: begin
                    vme_as_n <= 1'b0;
                    state    <= S_STROBE;
                end
                S_STROBE: begin
                    vme_ds0_n <= 1'b0;
                    timer     <= '0;
                    state     <= S_WAIT;
                end
                S_WAIT: begin
                    timer <= timer + TW'(1);
                    if (!berr_sync || !dtack_sync || timer_last_c) begin
                        // BERR outranks DTACK; DTACK outranks a coincident timeout.
                        if (!berr_sync) begin
                            cpu_vector <= SPURIOUS_VECTOR;
                            cpu_berr   <= 1'b1;
                        end else if (!dtack_sync) begin
                            cpu_vector <= vme_data;
                            cpu_berr   <= 1'b0;
                        end else begin
                            cpu_vector <= SPURIOUS_VECTOR;
                            cpu_berr   <= 1'b1;
                        end
                        vme_iack_n <= 1'b1;
                        vme_as_n   <= 1'b1;
                        vme_ds0_n  <= 1'b1;
                        timer      <= '0;
                        state      <= S_RELEASE;
                    end
                end
                S_RELEASE: begin
                    timer <= timer + TW'(1);
                    if ((dtack_sync && berr_sync) || timer_last_c) begin
                        cpu_iack_done <= 1'b1;
                        bus_req       <= 1'b0;
                        timer         <= '0;
                        state         <= S_IDLE;
                    end
                end
                default: begin
                    bus_req        <= 1'b0;
                    vme_iack_n     <= 1'b1;
                    vme_as_n       <= 1'b1;
                    vme_ds0_n      <= 1'b1;
                    vme_addr_level <= 3'd0;
                    timer          <= '0;
                    state          <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vme_iack_controller.sv
// Directed bench for vme_iack_controller: priority encoding, normal, spurious,
// timeout, BERR/DTACK priority and asynchronous reset in mid-cycle.
module tb_vme_iack_controller;

    logic       clock;
    logic       reset_n;
    logic [6:0] irq_n;
    logic [2:0] ipl;
    logic       cpu_iack_req;
    logic       cpu_iack_done;
    logic [7:0] cpu_vector;
    logic       cpu_berr;
    logic       bus_req;
    logic       bus_grant;
    logic       vme_iack_n;
    logic       vme_as_n;
    logic       vme_ds0_n;
    logic [2:0] vme_addr_level;
    logic [7:0] vme_data;
    logic       vme_dtack_n;
    logic       vme_berr_n;

    int vectors;
    int miscompares;

    vme_iack_controller #(
        .TIMEOUT_CYCLES (64),
        .SPURIOUS_VECTOR(8'h18)
    ) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .irq_n         (irq_n),
        .ipl           (ipl),
        .cpu_iack_req  (cpu_iack_req),
        .cpu_iack_done (cpu_iack_done),
        .cpu_vector    (cpu_vector),
        .cpu_berr      (cpu_berr),
        .bus_req       (bus_req),
        .bus_grant     (bus_grant),
        .vme_iack_n    (vme_iack_n),
        .vme_as_n      (vme_as_n),
        .vme_ds0_n     (vme_ds0_n),
        .vme_addr_level(vme_addr_level),
        .vme_data      (vme_data),
        .vme_dtack_n   (vme_dtack_n),
        .vme_berr_n    (vme_berr_n)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Pulses the request with ipl and grant already valid; returns on the WAIT-entry negedge.
    task automatic start_cycle();
        cpu_iack_req = 1'b1;
        tick(1);
        cpu_iack_req = 1'b0;
        check("start_bus_req", 8'(bus_req), 8'd1);
        tick(3);
        check("start_ds0_low", 8'(vme_ds0_n), 8'd0);
    endtask

    initial begin
        vectors      = 0;
        miscompares  = 0;
        reset_n      = 1'b0;
        irq_n        = 7'h7F;
        cpu_iack_req = 1'b0;
        bus_grant    = 1'b0;
        vme_data     = 8'h00;
        vme_dtack_n  = 1'b1;
        vme_berr_n   = 1'b1;
        tick(3);
        reset_n = 1'b1;
        tick(1);

        // Reset state
        check("rst_ipl", 8'(ipl), 8'd0);
        check("rst_bus_req", 8'(bus_req), 8'd0);
        check("rst_iack", 8'(vme_iack_n), 8'd1);
        check("rst_as", 8'(vme_as_n), 8'd1);
        check("rst_ds0", 8'(vme_ds0_n), 8'd1);
        check("rst_done", 8'(cpu_iack_done), 8'd0);
        check("rst_vector", cpu_vector, 8'h00);

        // Normal cycle: levels 3 and 6 pending, level 6 wins after 3 clocks
        irq_n = 7'b1011011;
        tick(2);
        check("ipl_latency_2", 8'(ipl), 8'd0);
        tick(1);
        check("ipl_6", 8'(ipl), 8'd6);
        cpu_iack_req = 1'b1;
        tick(1);
        cpu_iack_req = 1'b0;
        check("n_bus_req", 8'(bus_req), 8'd1);
        check("n_iack_pre_grant", 8'(vme_iack_n), 8'd1);
        tick(1);
        check("n_iack_still_high", 8'(vme_iack_n), 8'd1);
        bus_grant = 1'b1;
        tick(1);
        check("n_iack_low", 8'(vme_iack_n), 8'd0);
        check("n_as_high", 8'(vme_as_n), 8'd1);
        check("n_addr_level", 8'(vme_addr_level), 8'd6);
        tick(1);
        check("n_as_low", 8'(vme_as_n), 8'd0);
        check("n_ds0_high", 8'(vme_ds0_n), 8'd1);
        tick(1);
        check("n_ds0_low", 8'(vme_ds0_n), 8'd0);
        bus_grant   = 1'b0;
        vme_dtack_n = 1'b0;
        vme_data    = 8'h40;
        tick(2);
        check("n_ds0_held", 8'(vme_ds0_n), 8'd0);
        tick(1);
        check("n_ds0_release", 8'(vme_ds0_n), 8'd1);
        check("n_as_release", 8'(vme_as_n), 8'd1);
        check("n_iack_release", 8'(vme_iack_n), 8'd1);
        check("n_vector", cpu_vector, 8'h40);
        check("n_berr", 8'(cpu_berr), 8'd0);
        check("n_done_early", 8'(cpu_iack_done), 8'd0);
        vme_dtack_n = 1'b1;
        vme_data    = 8'h00;
        tick(2);
        check("n_done_wait", 8'(cpu_iack_done), 8'd0);
        check("n_bus_req_held", 8'(bus_req), 8'd1);
        tick(1);
        check("n_done_pulse", 8'(cpu_iack_done), 8'd1);
        check("n_bus_req_drop", 8'(bus_req), 8'd0);
        check("n_vector_hold", cpu_vector, 8'h40);
        tick(1);
        check("n_done_single", 8'(cpu_iack_done), 8'd0);

        // Spurious request: nothing pending
        irq_n = 7'h7F;
        tick(3);
        check("sp_ipl0", 8'(ipl), 8'd0);
        cpu_iack_req = 1'b1;
        tick(1);
        cpu_iack_req = 1'b0;
        check("sp_done", 8'(cpu_iack_done), 8'd1);
        check("sp_vector", cpu_vector, 8'h18);
        check("sp_berr", 8'(cpu_berr), 8'd1);
        check("sp_bus_req", 8'(bus_req), 8'd0);
        tick(1);
        check("sp_done_single", 8'(cpu_iack_done), 8'd0);
        check("sp_bus_req2", 8'(bus_req), 8'd0);

        // Timeout with no responder; level stays frozen when IRQs change
        irq_n = 7'b1111110;
        tick(3);
        check("to_ipl1", 8'(ipl), 8'd1);
        bus_grant = 1'b1;
        start_cycle();
        irq_n = 7'b0111111;
        tick(63);
        check("to_ds0_held", 8'(vme_ds0_n), 8'd0);
        check("to_level_frozen", 8'(vme_addr_level), 8'd1);
        tick(1);
        check("to_ds0_release", 8'(vme_ds0_n), 8'd1);
        check("to_vector", cpu_vector, 8'h18);
        check("to_berr", 8'(cpu_berr), 8'd1);
        tick(1);
        check("to_done", 8'(cpu_iack_done), 8'd1);
        tick(1);

        // DTACK and BERR together: BERR wins
        irq_n = 7'b1110111;
        tick(3);
        check("pr_ipl4", 8'(ipl), 8'd4);
        start_cycle();
        check("pr_addr_level", 8'(vme_addr_level), 8'd4);
        vme_dtack_n = 1'b0;
        vme_berr_n  = 1'b0;
        vme_data    = 8'h55;
        tick(3);
        check("pr_ds0_release", 8'(vme_ds0_n), 8'd1);
        check("pr_vector", cpu_vector, 8'h18);
        check("pr_berr", 8'(cpu_berr), 8'd1);
        vme_dtack_n = 1'b1;
        vme_berr_n  = 1'b1;
        tick(2);
        check("pr_done_wait", 8'(cpu_iack_done), 8'd0);
        tick(1);
        check("pr_done", 8'(cpu_iack_done), 8'd1);
        tick(1);

        // DTACK seen on the timeout clock: DTACK wins
        start_cycle();
        tick(61);
        vme_dtack_n = 1'b0;
        vme_data    = 8'hA5;
        tick(2);
        check("tt_ds0_held", 8'(vme_ds0_n), 8'd0);
        tick(1);
        check("tt_ds0_release", 8'(vme_ds0_n), 8'd1);
        check("tt_vector", cpu_vector, 8'hA5);
        check("tt_berr", 8'(cpu_berr), 8'd0);
        vme_dtack_n = 1'b1;
        tick(3);
        check("tt_done", 8'(cpu_iack_done), 8'd1);
        tick(1);

        // Asynchronous reset in WAIT
        start_cycle();
        tick(5);
        reset_n = 1'b0;
        #1;
        check("ar_ds0", 8'(vme_ds0_n), 8'd1);
        check("ar_as", 8'(vme_as_n), 8'd1);
        check("ar_iack", 8'(vme_iack_n), 8'd1);
        check("ar_bus_req", 8'(bus_req), 8'd0);
        check("ar_done", 8'(cpu_iack_done), 8'd0);
        tick(1);
        reset_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick(1);
            check("ar_no_done", 8'(cpu_iack_done), 8'd0);
            check("ar_no_bus_req", 8'(bus_req), 8'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
